sar_search: RTL
===============

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have parameter: WIDTH, default 10, bit width of trial, result and internal accumulator.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-004 SHALL have port: start  input  1  begin a search; sampled each rising clk.
REQ-005 SHALL have port: gt_in  input  1  result of an external unsigned greater-than comparator; 1 = target > trial.
REQ-006 SHALL have port: trial  output  WIDTH  registered value driven to the comparator's b operand.
REQ-007 SHALL have port: result  output  WIDTH  recovered target value, held until the next accepted start.
REQ-008 SHALL have port: busy  output  1  high exactly while state = SEARCH.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking result valid.

Function
REQ-010 SHALL implement FSM states IDLE, SEARCH, DONE; the external comparator is purely combinational and gt_in is sampled on the same edge that ends each trial cycle.
REQ-011 SHALL accept start only in IDLE or DONE; on acceptance: state -> SEARCH, acc = 0, idx = WIDTH-1, trial = 2^(WIDTH-1) - 1 (10-bit: 511).
REQ-012 SHALL ignore start while in SEARCH, with no effect on trial, acc, idx or result.
REQ-013 SHALL, in SEARCH at bit idx = k, compute acc_next = acc | (gt_in << k); trial = acc | (2^k - 1), so bit k is kept iff target >= acc | 2^k.
REQ-014 SHALL, when k > 0, register acc = acc_next, idx = k-1, trial = acc_next | (2^(k-1) - 1).
REQ-015 SHALL, when k = 0, register result = acc_next, state -> DONE, and assert done for exactly that DONE cycle.
REQ-016 SHALL complete in exactly WIDTH SEARCH cycles; done is high on the (WIDTH+1)th rising edge after the start-accepting edge.
REQ-017 SHALL leave DONE after one cycle, to SEARCH if start is high in that cycle, else to IDLE (back-to-back searches supported).
REQ-018 SHALL drive trial = 0 in IDLE and DONE.
REQ-019 SHALL produce result equal to the comparator target for every target in 0 .. 2^WIDTH-1, including both extremes.
REQ-020 SHALL perform all arithmetic unsigned, at WIDTH bits, with no carry or wrap beyond WIDTH.

Reset
REQ-021 SHALL, when reset = 0 at a rising clk, set state = IDLE, trial = 0, result = 0, acc = 0, idx = WIDTH-1, busy = 0, done = 0.
REQ-022 SHALL give reset priority over start and over any in-progress SEARCH; an interrupted search produces no done pulse.
REQ-023 SHALL accept start on the first rising edge with reset = 1.

Configuration
REQ-024 SHALL, when macro SAR_SEARCH_ABORT_EN is defined, add port abort (input, 1); abort = 1 in SEARCH forces IDLE next cycle, trial = 0, result unchanged, no done pulse.
REQ-025 SHALL, when SAR_SEARCH_ABORT_EN is defined, give abort priority over start in SEARCH, ignore abort in IDLE/DONE, and let start win if both are asserted in IDLE/DONE.
REQ-026 SHALL, when SAR_SEARCH_ABORT_EN is undefined, omit the abort port, with SEARCH always running to completion.

Verification
REQ-027 SHALL cover: target = 512, start pulse -> trial sequence 511, 767, 639, 575, 543, 527, 519, 515, 513, 512; done at edge 11; result = 512.
REQ-028 SHALL cover: targets 0 and 1023 -> result 0 and 1023 respectively; busy high for exactly 10 cycles each.
REQ-029 SHALL cover: target = 682 with start held high continuously -> results 682 on consecutive done pulses 11 cycles apart, with start ignored mid-search.
REQ-030 SHALL cover: reset = 0 at SEARCH cycle 5, target = 300 -> next cycle IDLE, trial = 0, result = 0, no done; a new start then yields 300.
REQ-031 SHALL cover (with SAR_SEARCH_ABORT_EN): prior result 100, new search target 900, abort at SEARCH cycle 3 -> IDLE, result stays 100, no done.
REQ-032 SHALL cover: exhaustive sweep of targets 0..1023 against a behavioural comparator -> result == target for all targets.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown target one bit per
// cycle using an external greater-than comparator. Optional abort: SAR_SEARCH_ABORT_EN.
module sar_search #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SAR_SEARCH_ABORT_EN
   input  logic             abort,
`endif
   input  logic             gt_in,
   output logic [WIDTH-1:0] trial,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } state_t;

   state_t           st, st_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0] acc_or;
   logic [WIDTH-1:0] trial_n;
   logic [WIDTH-1:0] result_n;
   logic [IW-1:0]    idx, idx_n;
   logic [IW-1:0]    idx_m1;
   logic             abort_q;

`ifdef SAR_SEARCH_ABORT_EN
   assign abort_q = abort;
`else
   assign abort_q = 1'b0;
`endif

   assign acc_or = acc | (WIDTH'(gt_in) << idx);
   assign idx_m1 = idx - IW'(1);
   assign busy   = (st == SEARCH);
   assign done   = (st == DONE);

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         st     <= IDLE;
         acc    <= '0;
         idx    <= TOP;
         trial  <= '0;
         result <= '0;
      end else begin
         st     <= st_n;
         acc    <= acc_n;
         idx    <= idx_n;
         trial  <= trial_n;
         result <= result_n;
      end
   end

   // Next-state and next-datapath decode; a search owns the FSM until done or abort
   always_comb begin
      st_n     = st;
      acc_n    = acc;
      idx_n    = idx;
      trial_n  = trial;
      result_n = result;
      unique case (st)
         SEARCH: begin
            if (abort_q) begin
               st_n    = IDLE;
               trial_n = '0;
            end else if (idx == '0) begin
               st_n     = DONE;
               acc_n    = acc_or;
               result_n = acc_or;
               trial_n  = '0;
            end else begin
               acc_n   = acc_or;
               idx_n   = idx_m1;
               trial_n = acc_or | ((ONE << idx_m1) - ONE);
            end
         end
         IDLE, DONE: begin
            if (start) begin
               st_n    = SEARCH;
               acc_n   = '0;
               idx_n   = TOP;
               trial_n = (ONE << TOP) - ONE;
            end else begin
               st_n    = IDLE;
               trial_n = '0;
            end
         end
         default: begin
            st_n    = IDLE;
            trial_n = '0;
         end
      endcase
   end

endmodule
